// File: rtl/demux_sel_sequencer_pkg.sv
// rtl/demux_sel_sequencer_pkg.sv - shared constants, FSM encoding and channel helper for the demux select sequencer
package demux_sel_sequencer_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lowest set bit of mask; 0 when mask is empty.
  function automatic logic [SELW-1:0] lowest_ch(input logic [NCH-1:0] mask);
    lowest_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_ch = SELW'(i);
    end
  endfunction

endpackage

// File: rtl/demux_next_ch.sv
// rtl/demux_next_ch.sv - next enabled channel above cur (with wrap) and lowest enabled channel
module demux_next_ch
  import demux_sel_sequencer_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur,
  output logic [SELW-1:0] nxt,
  output logic            wrap,
  output logic [SELW-1:0] first
);

  logic            found;
  logic [SELW-1:0] idx;

  // Offset NCH lands back on cur, so a lone enabled channel re-selects itself.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = 1; i <= NCH; i++) begin
      idx = cur + SELW'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign wrap  = (nxt <= cur);
  assign first = lowest_ch(mask);

endmodule

// File: rtl/demux_sel_sequencer.sv
// rtl/demux_sel_sequencer.sv - steps the 1-to-8 demux select over enabled channels with a programmable dwell
module demux_sel_sequencer
  import demux_sel_sequencer_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          mode_cont,
  input  logic [7:0]    ch_mask,
  input  logic [DW-1:0] dwell,
  input  logic          din_in,
  output logic          din,
  output logic          s2,
  output logic          s1,
  output logic          s0,
  output logic          busy,
  output logic          done
);

  localparam logic [DW-1:0] ONE = DW'(1);

  state_t          state;
  logic [DW-1:0]   cnt;
  logic [DW-1:0]   dwell_q;
  logic [NCH-1:0]  mask_q;
  logic            mode_q;
  logic [SELW-1:0] sel;

  logic [DW-1:0]   dwell_eff;
  logic [SELW-1:0] nxt;
  logic [SELW-1:0] first;
  logic            wrap;

  assign dwell_eff = (dwell == '0) ? ONE : dwell;
  assign {s2, s1, s0} = sel;

  demux_next_ch u_next (
    .mask  (mask_q),
    .cur   (sel),
    .nxt   (nxt),
    .wrap  (wrap),
    .first (first)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      sel     <= '0;
      din     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop && (ch_mask != '0)) begin
            state   <= ST_RUN;
            mask_q  <= ch_mask;
            mode_q  <= mode_cont;
            dwell_q <= dwell_eff;
            cnt     <= dwell_eff - ONE;
            sel     <= lowest_ch(ch_mask);
            busy    <= 1'b1;
            din     <= din_in;
          end else begin
            sel  <= '0;
            busy <= 1'b0;
            din  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            sel   <= '0;
            busy  <= 1'b0;
            din   <= 1'b0;
          end else if (cnt == '0) begin
            // Wrap at expiry means the highest enabled channel just finished.
            if (wrap && !mode_q) begin
              state <= ST_DONE;
              sel   <= '0;
              busy  <= 1'b0;
              din   <= 1'b0;
              done  <= 1'b1;
            end else begin
              sel <= wrap ? first : nxt;
              cnt <= dwell_q - ONE;
              din <= din_in;
            end
          end else begin
            cnt <= cnt - ONE;
            din <= din_in;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          sel   <= '0;
          busy  <= 1'b0;
          din   <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          sel   <= '0;
          busy  <= 1'b0;
          din   <= 1'b0;
        end
      endcase
    end
  end

endmodule
